// File: rtl/pipelined_csel_addsub.sv
// pipelined_csel_addsub
//   Two-stage pipelined carry-select adder/subtractor with valid/ready flow control.
//   Stage 1 registers the operands on an input handshake. Stage 2 registers the
//   result computed from the stage-1 operands by a carry-select adder.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   BLOCK  carry-select block width; must divide WIDTH exactly
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   stage 1 can accept a beat this cycle (combinational from out_ready)
//   a, b       operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a + b + cin, 1: a - b - cin
//   out_valid  result beat valid
//   out_ready  consumer accepts the result this cycle
//   sum        result modulo 2^WIDTH
//   cout       raw carry out of the MSB (subtract: 1 means no borrow)
//   ovf        signed two's-complement overflow
module pipelined_csel_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NumBlk = (BLOCK == 0) ? 1 : WIDTH / BLOCK;

  if ((WIDTH < 2) || (BLOCK == 0) || ((WIDTH % BLOCK) != 0)) begin : g_bad_param
    $error("pipelined_csel_addsub: WIDTH must be >= 2 and a multiple of BLOCK");
  end

  // Ripple-carry adder for one block; returns {carry_out, sum}.
  function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] x,
                                            input logic [BLOCK-1:0] y,
                                            input logic             ci);
    logic             c;
    logic [BLOCK-1:0] s;
    c = ci;
    s = '0;
    for (int i = 0; i < BLOCK; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic             sub_q, sub_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             s2_load;
  logic             in_hs;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  // Stage 1 drains into stage 2 whenever stage 2 is empty or being consumed.
  assign s2_load  = s1_valid_q & (~out_valid_q | out_ready);
  // Combinational path from out_ready keeps full throughput under a stall-free
  // consumer without a skid buffer.
  assign in_ready = ~s1_valid_q | s2_load;
  assign in_hs    = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Carry-select datapath on stage-1 operands
  // ---------------------------------------------------------------------------
  // Subtraction as a - b - bin = a + ~b + ~bin.
  logic [WIDTH-1:0] bx;
  logic             c0;
  logic [NumBlk:0]  blk_c;
  logic [WIDTH-1:0] sum_c;
  logic             msb_cin;

  assign bx       = sub_q ? ~b_q : b_q;
  assign c0       = sub_q ? ~cin_q : cin_q;
  assign blk_c[0] = c0;

  for (genvar k = 0; k < NumBlk; k++) begin : g_blk
    if (k == 0) begin : g_first
      assign {blk_c[1], sum_c[BLOCK-1:0]} = ripple(a_q[BLOCK-1:0], bx[BLOCK-1:0], blk_c[0]);
    end else begin : g_sel
      logic [BLOCK:0] r0;
      logic [BLOCK:0] r1;
      assign r0 = ripple(a_q[k*BLOCK +: BLOCK], bx[k*BLOCK +: BLOCK], 1'b0);
      assign r1 = ripple(a_q[k*BLOCK +: BLOCK], bx[k*BLOCK +: BLOCK], 1'b1);
      // Previous block's carry picks the precomputed result.
      assign {blk_c[k+1], sum_c[k*BLOCK +: BLOCK]} = blk_c[k] ? r1 : r0;
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c.
  assign msb_cin = sum_c[WIDTH-1] ^ a_q[WIDTH-1] ^ bx[WIDTH-1];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = (in_hs) | (s1_valid_q & ~s2_load);
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    sub_d      = sub_q;
    if (in_hs) begin
      a_d   = a;
      b_d   = b;
      cin_d = cin;
      sub_d = sub;
    end
  end

  always_comb begin
    out_valid_d = s1_valid_q ? 1'b1 : (out_valid_q & ~out_ready);
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (s2_load) begin
      sum_d  = sum_c;
      cout_d = blk_c[NumBlk];
      ovf_d  = msb_cin ^ blk_c[NumBlk];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      sub_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      sub_q       <= sub_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_csel_addsub.sv
// Scoreboard bench for pipelined_csel_addsub (WIDTH=16, BLOCK=4).
module tb_pipelined_csel_addsub;

  localparam int unsigned W = 16;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  pipelined_csel_addsub #(
    .WIDTH(W),
    .BLOCK(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // {ovf, cout, sum} expected per accepted beat.
  logic [W+1:0] exp_q[$];

  // Reference occupancy of the two stages.
  logic m_s1  = 1'b0;
  logic m_out = 1'b0;

  // 0: always ready, 1: 1,0,0,1 pattern, 2: random, 3: never ready
  int ready_mode = 0;
  int cyc        = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic ci, input logic sb);
    logic [W-1:0] bxv;
    logic         c0v;
    logic [W:0]   r;
    logic         v;
    bxv = sb ? ~bv : bv;
    c0v = sb ? ~ci : ci;
    r   = {1'b0, av} + {1'b0, bxv} + {{W{1'b0}}, c0v};
    v   = (av[W-1] == bxv[W-1]) && (r[W-1] != av[W-1]);
    return {v, r[W], r[W-1:0]};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Consumer readiness, changed just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: inputs are stable at the falling edge, so this sees exactly what
  // the next rising edge will act on.
  always @(negedge clk) begin
    logic s2l;
    logic nxt_out;
    if (reset) begin
      exp_q.delete();
      m_s1  = 1'b0;
      m_out = 1'b0;
    end else begin
      check_eq("out_valid", out_valid, m_out);
      check_eq("in_ready", in_ready, !m_s1 || !m_out || out_ready);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", out_valid, 0);
        end else begin
          check_eq("result", {ovf, cout, sum}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      s2l = m_s1 && (!m_out || out_ready);
      if (in_valid && (!m_s1 || s2l)) exp_q.push_back(model(a, b, cin, sub));
      nxt_out = m_s1 ? 1'b1 : (m_out && !out_ready);
      m_s1    = (in_valid && (!m_s1 || s2l)) || (m_s1 && !s2l);
      m_out   = nxt_out;
    end
  end

  // Present a beat and hold it until accepted; leaves in_valid high so
  // consecutive sends stream back-to-back.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ci, input logic sb);
    logic hs;
    logic done;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = ci;
    sub      = sb;
    done     = 1'b0;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (hs) done = 1'b1;
    end
    if (!done) begin
      check_eq("send_timeout", in_ready, 1);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    sub      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_cout", cout, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed arithmetic corners, full-rate stream.
    ready_mode = 0;
    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    send(16'h0000, 16'h0000, 1'b1, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0);
    drain();

    // Backpressure stream.
    ready_mode = 1;
    for (int i = 1; i <= 8; i++) send(16'(i), 16'(i), 1'b0, 1'b0);
    drain();

    // Reset with two beats in flight.
    ready_mode = 3;
    @(posedge clk);
    #1;
    send(16'h0011, 16'h0022, 1'b0, 1'b0);
    send(16'h0033, 16'h0044, 1'b0, 1'b0);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_sum", sum, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    ready_mode = 0;
    send(16'd3, 16'd4, 1'b0, 1'b0);
    drain();

    // Random traffic.
    ready_mode = 2;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    ready_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
